// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with write-back bypass and a busy-bit scoreboard
// that raises hazard on RAW/WAW conflicts and flags unexpected writebacks.
module reg_file_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     rs1,
    input  logic [ADDR_W-1:0]     rs2,
    output logic [DATA_W-1:0]     rs1_data,
    output logic [DATA_W-1:0]     rs2_data,
    input  logic                  wb_en,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_rd,
    input  logic                  iss_use1,
    input  logic                  iss_use2,
    output logic                  hazard,
    output logic [2**ADDR_W-1:0]  busy,
    output logic                  wb_err
);
    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   wb_mask;
    logic [NREG-1:0]   iss_mask;
    logic [NREG-1:0]   eb;
    logic              wb_zero;
    logic              iss_zero;
    logic              accept;

    assign wb_zero  = (ZERO_REG != 0) && (wb_addr == '0);
    assign iss_zero = (ZERO_REG != 0) && (iss_rd == '0);
    assign wb_mask  = wb_en ? (NREG'(1) << wb_addr) : '0;
    // A writeback landing this cycle releases its register early only when it is forwarded.
    assign eb       = busy_q & ~((BYPASS != 0) ? wb_mask : '0);
    assign hazard   = iss_en & ((iss_use1 & eb[rs1]) | (iss_use2 & eb[rs2]) | eb[iss_rd]);
    assign accept   = iss_en & ~hazard;
    assign iss_mask = (accept && !iss_zero) ? (NREG'(1) << iss_rd) : '0;
    assign busy     = busy_q;

    assign rs1_data = ((ZERO_REG != 0) && rs1 == '0) ? '0 :
                      ((BYPASS != 0) && wb_en && wb_addr == rs1) ? wb_data : regs[rs1];
    assign rs2_data = ((ZERO_REG != 0) && rs2 == '0) ? '0 :
                      ((BYPASS != 0) && wb_en && wb_addr == rs2) ? wb_data : regs[rs2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            busy_q <= '0;
            wb_err <= 1'b0;
        end else begin
            if (wb_en && !wb_zero) regs[wb_addr] <= wb_data;
            // Set after clear so a same-edge issue and writeback leave the bit pending.
            busy_q <= (busy_q & ~wb_mask) | iss_mask;
            if (wb_en && !busy_q[wb_addr] && !wb_zero) wb_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed tests of reg_file_sb on three configurations
// (default, ZERO_REG=1, BYPASS=0) driven with identical stimulus.
module tb_reg_file_sb;
    logic        clk = 0;
    logic        rst;
    logic [3:0]  rs1, rs2, wb_addr, iss_rd;
    logic [7:0]  wb_data;
    logic        wb_en, iss_en, iss_use1, iss_use2;
    logic [7:0]  d_r1, d_r2, z_r1, z_r2, b_r1, b_r2;
    logic        d_hz, z_hz, b_hz, d_er, z_er, b_er;
    logic [15:0] d_bs, z_bs, b_bs;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.ZERO_REG(0), .BYPASS(1)) dut (.clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
        .rs1_data(d_r1), .rs2_data(d_r2), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .iss_use1(iss_use1), .iss_use2(iss_use2),
        .hazard(d_hz), .busy(d_bs), .wb_err(d_er));
    reg_file_sb #(.ZERO_REG(1), .BYPASS(1)) dz (.clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
        .rs1_data(z_r1), .rs2_data(z_r2), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .iss_use1(iss_use1), .iss_use2(iss_use2),
        .hazard(z_hz), .busy(z_bs), .wb_err(z_er));
    reg_file_sb #(.ZERO_REG(0), .BYPASS(0)) db (.clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
        .rs1_data(b_r1), .rs2_data(b_r2), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .iss_use1(iss_use1), .iss_use2(iss_use2),
        .hazard(b_hz), .busy(b_bs), .wb_err(b_er));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        {wb_en, iss_en, iss_use1, iss_use2} = '0;
        {rs1, rs2, wb_addr, iss_rd, wb_data} = '0;
        #1;
    endtask

    task automatic do_reset;
        idle();
        rst = 0;
        tick();
        rst = 1;
    endtask

    task automatic test_reset;
        rst = 1;
        idle();
        tick();
        do_reset();
        rs1 = 3; rs2 = 9; iss_rd = 3; #1;
        total++; if (d_bs !== 16'h0) begin bad++; $display("FAIL reset_busy got=%h want=0000", d_bs); end
        total++; if (d_er !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", d_er); end
        total++; if (d_r1 !== 8'h00 || d_r2 !== 8'h00) begin bad++; $display("FAIL reset_read got=%h/%h want=00/00", d_r1, d_r2); end
        total++; if (d_hz !== 1'b0) begin bad++; $display("FAIL reset_hazard_noiss got=%b want=0", d_hz); end
    endtask

    task automatic test_write_read;
        idle();
        iss_en = 1; iss_rd = 3; #1;
        tick();
        idle();
        total++; if (d_bs !== 16'h0008) begin bad++; $display("FAIL wr_issue_busy got=%h want=0008", d_bs); end
        wb_en = 1; wb_addr = 3; wb_data = 8'hA5; rs1 = 3; #1;
        total++; if (d_r1 !== 8'hA5) begin bad++; $display("FAIL wr_bypass got=%h want=a5", d_r1); end
        total++; if (b_r1 !== 8'h00) begin bad++; $display("FAIL wr_nobypass got=%h want=00", b_r1); end
        tick();
        idle();
        rs1 = 3; rs2 = 3; #1;
        total++; if (d_r1 !== 8'hA5 || d_r2 !== 8'hA5) begin bad++; $display("FAIL wr_read got=%h/%h want=a5/a5", d_r1, d_r2); end
        total++; if (d_bs !== 16'h0 || d_er !== 1'b0) begin bad++; $display("FAIL wr_state busy=%h err=%b want=0000/0", d_bs, d_er); end
    endtask

    task automatic test_raw;
        idle();
        iss_en = 1; iss_rd = 5; #1;
        total++; if (d_hz !== 1'b0) begin bad++; $display("FAIL raw_first_hz got=%b want=0", d_hz); end
        tick();
        total++; if (d_bs !== 16'h0020) begin bad++; $display("FAIL raw_busy5 got=%h want=0020", d_bs); end
        idle();
        iss_en = 1; rs1 = 5; iss_use1 = 1; iss_rd = 6; #1;
        total++; if (d_hz !== 1'b1) begin bad++; $display("FAIL raw_stall got=%b want=1", d_hz); end
        iss_use1 = 0; rs2 = 5; iss_use2 = 1; #1;
        total++; if (d_hz !== 1'b1) begin bad++; $display("FAIL raw_stall_rs2 got=%b want=1", d_hz); end
        iss_use2 = 0; #1;
        total++; if (d_hz !== 1'b0) begin bad++; $display("FAIL raw_unused_src got=%b want=0", d_hz); end
        iss_use1 = 1; #1;
        tick();
        total++; if (d_bs !== 16'h0020) begin bad++; $display("FAIL raw_stall_hold got=%h want=0020", d_bs); end
        wb_en = 1; wb_addr = 5; wb_data = 8'h3C; #1;
        total++; if (d_hz !== 1'b0 || d_r1 !== 8'h3C) begin bad++; $display("FAIL raw_bypass hz=%b data=%h want=0/3c", d_hz, d_r1); end
        total++; if (b_hz !== 1'b1 || b_r1 !== 8'h00) begin bad++; $display("FAIL raw_nobypass hz=%b data=%h want=1/00", b_hz, b_r1); end
        tick();
        total++; if (d_bs !== 16'h0040) begin bad++; $display("FAIL raw_accept got=%h want=0040", d_bs); end
        idle();
        wb_en = 1; wb_addr = 6; wb_data = 8'h66; #1;
        tick();
        total++; if (d_bs !== 16'h0 || d_er !== 1'b0) begin bad++; $display("FAIL raw_clean busy=%h err=%b want=0000/0", d_bs, d_er); end
    endtask

    task automatic test_waw;
        idle();
        iss_en = 1; iss_rd = 7; #1;
        tick();
        total++; if (d_bs !== 16'h0080) begin bad++; $display("FAIL waw_busy7 got=%h want=0080", d_bs); end
        iss_en = 1; iss_rd = 7; wb_en = 1; wb_addr = 7; wb_data = 8'h11; #1;
        total++; if (d_hz !== 1'b0) begin bad++; $display("FAIL waw_bypass_hz got=%b want=0", d_hz); end
        tick();
        idle();
        rs1 = 7; #1;
        total++; if (d_bs !== 16'h0080) begin bad++; $display("FAIL waw_set_wins got=%h want=0080", d_bs); end
        total++; if (d_r1 !== 8'h11 || d_er !== 1'b0) begin bad++; $display("FAIL waw_data data=%h err=%b want=11/0", d_r1, d_er); end
        iss_en = 1; iss_rd = 7; #1;
        total++; if (d_hz !== 1'b1) begin bad++; $display("FAIL waw_hazard got=%b want=1", d_hz); end
        idle();
        wb_en = 1; wb_addr = 7; wb_data = 8'h12; #1;
        tick();
    endtask

    task automatic test_err;
        idle();
        wb_en = 1; wb_addr = 9; wb_data = 8'h01; #1;
        total++; if (d_er !== 1'b0) begin bad++; $display("FAIL err_early got=%b want=0", d_er); end
        tick();
        idle();
        rs2 = 9; #1;
        total++; if (d_er !== 1'b1 || d_r2 !== 8'h01) begin bad++; $display("FAIL err_set err=%b data=%h want=1/01", d_er, d_r2); end
        iss_en = 1; iss_rd = 1; #1;
        tick();
        idle();
        wb_en = 1; wb_addr = 1; wb_data = 8'h77; #1;
        tick();
        idle();
        total++; if (d_er !== 1'b1 || d_bs !== 16'h0) begin bad++; $display("FAIL err_sticky err=%b busy=%h want=1/0000", d_er, d_bs); end
    endtask

    task automatic test_reset_mid;
        idle();
        iss_en = 1; iss_rd = 2; #1;
        tick();
        iss_rd = 4; #1;
        tick();
        idle();
        iss_en = 1; iss_rd = 2; wb_en = 1; wb_addr = 2; wb_data = 8'h55; #1;
        tick();
        idle();
        rs1 = 2; #1;
        total++; if (d_bs !== 16'h0014 || d_r1 !== 8'h55) begin bad++; $display("FAIL mid_setup busy=%h data=%h want=0014/55", d_bs, d_r1); end
        rst = 0; iss_en = 1; iss_rd = 8; wb_en = 1; wb_addr = 4; wb_data = 8'h99; #1;
        tick();
        rst = 1;
        idle();
        rs1 = 2; rs2 = 4; #1;
        total++; if (d_bs !== 16'h0 || d_er !== 1'b0) begin bad++; $display("FAIL mid_reset busy=%h err=%b want=0000/0", d_bs, d_er); end
        total++; if (d_r1 !== 8'h00 || d_r2 !== 8'h00) begin bad++; $display("FAIL mid_regs got=%h/%h want=00/00", d_r1, d_r2); end
        iss_en = 1; iss_rd = 2; #1;
        total++; if (d_hz !== 1'b0) begin bad++; $display("FAIL mid_reissue_hz got=%b want=0", d_hz); end
        tick();
        total++; if (d_bs !== 16'h0004) begin bad++; $display("FAIL mid_reissue_busy got=%h want=0004", d_bs); end
    endtask

    task automatic test_zero;
        do_reset();
        wb_en = 1; wb_addr = 0; wb_data = 8'hFF; iss_en = 1; iss_rd = 0; rs1 = 0; #1;
        total++; if (z_r1 !== 8'h00 || z_hz !== 1'b0) begin bad++; $display("FAIL zero_comb data=%h hz=%b want=00/0", z_r1, z_hz); end
        total++; if (d_r1 !== 8'hFF) begin bad++; $display("FAIL zero_off_bypass got=%h want=ff", d_r1); end
        tick();
        idle();
        rs1 = 0; #1;
        total++; if (z_bs !== 16'h0 || z_er !== 1'b0 || z_r1 !== 8'h00) begin bad++; $display("FAIL zero_state busy=%h err=%b data=%h want=0000/0/00", z_bs, z_er, z_r1); end
        total++; if (d_bs !== 16'h0001 || d_er !== 1'b1 || d_r1 !== 8'hFF) begin bad++; $display("FAIL zero_off_state busy=%h err=%b data=%h want=0001/1/ff", d_bs, d_er, d_r1); end
        iss_en = 1; iss_rd = 0; #1;
        total++; if (z_hz !== 1'b0 || d_hz !== 1'b1) begin bad++; $display("FAIL zero_reissue zhz=%b dhz=%b want=0/1", z_hz, d_hz); end
        tick();
        total++; if (z_bs !== 16'h0) begin bad++; $display("FAIL zero_never_busy got=%h want=0000", z_bs); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_raw();
        test_waw();
        test_err();
        test_reset_mid();
        test_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 4, register address width; depth NREG = 2**ADDR_W.
REQ-003 The block SHALL have parameter ZERO_REG, default 0; when 1, register 0 is hardwired to zero.
REQ-004 The block SHALL have parameter BYPASS, default 1; when 1, same-cycle writeback is forwarded to the read ports.
REQ-005 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-006 The block SHALL have port rst, input, 1, reset; synchronous, active-low.
REQ-007 The block SHALL have ports rs1 and rs2, each input, ADDR_W, read addresses.
REQ-008 The block SHALL have ports rs1_data and rs2_data, each output, DATA_W, read data.
REQ-009 The block SHALL have port wb_en, input, 1, writeback strobe.
REQ-010 The block SHALL have ports wb_addr (input, ADDR_W) and wb_data (input, DATA_W), writeback target and value.
REQ-011 The block SHALL have port iss_en, input, 1, instruction issue request.
REQ-012 The block SHALL have port iss_rd, input, ADDR_W, destination of the issuing instruction.
REQ-013 The block SHALL have ports iss_use1 and iss_use2, each input, 1, flags marking rs1 and rs2 as read by the issuing instruction.
REQ-014 The block SHALL have port hazard, output, 1, issue-stall request.
REQ-015 The block SHALL have port busy, output, NREG, scoreboard vector; bit r set means a write to r is pending.
REQ-016 The block SHALL have port wb_err, output, 1, sticky protocol-error flag.

Function
REQ-017 Array write: on a clk edge with rst high and wb_en=1, reg[wb_addr] SHALL take wb_data; the write is ignored when ZERO_REG=1 and wb_addr=0.
REQ-018 Reads SHALL be combinational: rsN_data = reg[rsN], except as set by REQ-019 and REQ-020.
REQ-019 With BYPASS=1, wb_en=1 and wb_addr=rsN, rsN_data SHALL equal wb_data in the same cycle.
REQ-020 With ZERO_REG=1 and rsN=0, rsN_data SHALL be 0 regardless of REQ-019.
REQ-021 Effective busy: eb(r) = busy[r] AND NOT(BYPASS AND wb_en AND wb_addr=r).
REQ-022 Hazard: hazard = iss_en AND ((iss_use1 AND eb(rs1)) OR (iss_use2 AND eb(rs2)) OR eb(iss_rd)) (RAW plus WAW); combinational; hazard SHALL be 0 whenever iss_en=0.
REQ-023 Issue accept: an issue is accepted when iss_en=1 and hazard=0; on that edge busy[iss_rd] SHALL be set (one-cycle latency to the busy output).
REQ-024 Writeback clear: on an edge with wb_en=1, busy[wb_addr] SHALL be cleared.
REQ-025 Simultaneous: an accepted issue and a writeback to the same register on the same edge SHALL leave busy set and write wb_data to the array.
REQ-026 Zero register: with ZERO_REG=1, busy[0] SHALL never be set, and iss_rd=0 SHALL never cause a hazard.
REQ-027 Error: an edge with wb_en=1 and busy[wb_addr]=0 (excluding register 0 when ZERO_REG=1) SHALL set wb_err; the data is still written; wb_err stays 1 until reset.
REQ-028 Hazard evaluation SHALL use rs1 and rs2 as supplied in the issue cycle; no state SHALL change while hazard=1 except through writeback.

Reset
REQ-029 On a clk edge with rst=0, all NREG registers SHALL become 0, busy SHALL become all-zero and wb_err SHALL become 0.
REQ-030 Reset SHALL take priority over wb_en and iss_en on the same edge, including mid-operation with pending busy bits; those bits are discarded.
REQ-031 rst SHALL have no asynchronous effect; outputs SHALL change only at clk edges or through combinational paths from inputs.

Verification
REQ-032 The bench SHALL cover write then read: wb reg3=0xA5; next cycle rs1=3 -> rs1_data=0xA5; busy all-zero after reset.
REQ-033 The bench SHALL cover RAW stall: issue iss_rd=5, accepted, busy[5]=1; next cycle iss_en with rs1=5, iss_use1=1 -> hazard=1; same cycle wb reg5=0x3C with BYPASS=1 -> hazard=0 and rs1_data=0x3C.
REQ-034 The bench SHALL cover WAW with simultaneous set/clear: busy[7]=1; a cycle with wb reg7=0x11 plus an issue of iss_rd=7 -> next cycle busy[7]=1 and reg7=0x11.
REQ-035 The bench SHALL cover the zero register: ZERO_REG=1; wb reg0=0xFF and an issue of iss_rd=0 -> rs1_data for rs1=0 is 0, busy[0]=0, hazard=0, wb_err=0.
REQ-036 The bench SHALL cover the error flag: wb reg9=0x01 with busy[9]=0 -> wb_err=1 next cycle, reg9=0x01; wb_err holds across further traffic until rst=0.
REQ-037 The bench SHALL cover reset mid-operation: busy[2]=1 and busy[4]=1, reg2=0x55; rst=0 for one edge -> busy=0, reg2=0, wb_err=0; a later issue of iss_rd=2 sees no hazard.
